// File: rtl/rect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rect_pkg
// Description : Shared types for the rect position update scheduler.
//               - rect_pos_t      : one (x,y) coordinate pair, 12 bits each
//               - sched_state_t   : scheduler FSM states
//               - SLOT_CYCLES_DEF : default per-slot timeout in clock cycles
// Revision    : 1.0 - initial release
// ============================================================================
package rect_pkg;

    localparam int SLOT_CYCLES_DEF = 64;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } rect_pos_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNAP   = 3'd1,
        GRANT  = 3'd2,
        WAIT   = 3'd3,
        COMMIT = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-set finder. Scans vec
//               starting at index start, wrapping at N, and returns the
//               first set bit.
// Ports       : vec    in  N      candidate bits
//               start  in  PTR_W  index to begin the scan at
//               onehot out N      one-hot of the chosen bit (0 if none)
//               idx    out PTR_W  index of the chosen bit
//               valid  out 1      at least one bit of vec is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W-1:0] w_k;

    always_comb begin : p_pick
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        w_k    = '0;
        for (int i = 0; i < N; i++) begin
            // Modulo keeps the scan correct for non-power-of-two N.
            w_k = PTR_W'((int'(start) + i) % N);
            if (!valid && vec[w_k]) begin
                valid       = 1'b1;
                idx         = w_k;
                onehot[w_k] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rect_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : rect_update_sched
// Description : Frame-synchronous scheduler sharing one position bank among
//               N rect controllers. On each vblank rise the request vector
//               is snapshotted; each requester gets one slot in round-robin
//               order, its (x,y) is captured into a shadow register, and all
//               shadows are committed to the output bank in a single cycle.
// Ports       : clk          in   1      pixel clock
//               rst_n        in   1      async active-low reset
//               vblank       in   1      vertical blank, level
//               req          in   N      client wants a slot this frame
//               done         in   N      client position valid (1-cycle)
//               cl_xpos/ypos in   Nx12   client positions
//               grant        out  N      one-hot or zero slot owner
//               xpos/ypos    out  Nx12   committed position bank
//               commit       out  1      pulse when the bank updates
//               timeout_err  out  N      sticky per-client slot timeout
// Revision    : 1.0 - initial release
// ============================================================================
module rect_update_sched
    import rect_pkg::*;
#(
    parameter int N_CLIENTS   = 4,
    parameter int SLOT_CYCLES = SLOT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vblank,
    input  logic [N_CLIENTS-1:0]      req,
    input  logic [N_CLIENTS-1:0]      done,
    input  logic [N_CLIENTS-1:0][11:0] cl_xpos,
    input  logic [N_CLIENTS-1:0][11:0] cl_ypos,
    output logic [N_CLIENTS-1:0]      grant,
    output logic [N_CLIENTS-1:0][11:0] xpos,
    output logic [N_CLIENTS-1:0][11:0] ypos,
    output logic                      commit,
    output logic [N_CLIENTS-1:0]      timeout_err
);

    localparam int c_ptr_w = $clog2(N_CLIENTS);
    localparam int c_cnt_w = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SLOT_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(N_CLIENTS - 1);

    sched_state_t r_state, w_state_nx;

    logic                        r_vblank_prv;
    logic [N_CLIENTS-1:0]        r_pend;
    logic [N_CLIENTS-1:0]        r_grant;
    logic [c_ptr_w-1:0]          r_gidx;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [c_ptr_w-1:0]          r_rr_ptr;
    logic                        r_first_vld;
    logic [c_ptr_w-1:0]          r_first_idx;
    rect_pos_t [N_CLIENTS-1:0]   r_shadow;
    logic [N_CLIENTS-1:0][11:0]  r_xpos;
    logic [N_CLIENTS-1:0][11:0]  r_ypos;
    logic                        r_commit;
    logic [N_CLIENTS-1:0]        r_timeout_err;

    logic [N_CLIENTS-1:0]        w_pick_oh;
    logic [c_ptr_w-1:0]          w_pick_idx;
    logic                        w_pick_vld;
    logic                        w_vb_rise;
    logic                        w_hit;

    // FSM strobes
    logic w_snap, w_issue, w_take, w_tmo, w_abort, w_cnt_inc, w_commit_now;

    rr_pick #(
        .N     (N_CLIENTS),
        .PTR_W (c_ptr_w)
    ) u_rr_pick (
        .vec    (r_pend),
        .start  (r_rr_ptr),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .valid  (w_pick_vld)
    );

    assign w_vb_rise = vblank & ~r_vblank_prv;
    // Only the current slot owner's done counts; strays from others are dropped.
    assign w_hit     = |(done & r_grant);

    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin : p_fsm_next
        w_state_nx   = r_state;
        w_snap       = 1'b0;
        w_issue      = 1'b0;
        w_take       = 1'b0;
        w_tmo        = 1'b0;
        w_abort      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_commit_now = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vb_rise) w_state_nx = SNAP;
            end
            SNAP: begin
                w_snap     = 1'b1;
                w_state_nx = GRANT;
            end
            GRANT: begin
                if (!vblank) begin
                    w_abort    = 1'b1;
                    w_state_nx = COMMIT;
                end else if (w_pick_vld) begin
                    w_issue    = 1'b1;
                    w_state_nx = WAIT;
                end else begin
                    w_state_nx = COMMIT;
                end
            end
            WAIT: begin
                // Leaving vblank ends the frame; done beats timeout.
                if (!vblank) begin
                    w_abort    = 1'b1;
                    w_state_nx = COMMIT;
                end else if (w_hit) begin
                    w_take     = 1'b1;
                    w_state_nx = GRANT;
                end else if (r_cnt == c_cnt_last) begin
                    w_tmo      = 1'b1;
                    w_state_nx = GRANT;
                end else begin
                    w_cnt_inc  = 1'b1;
                end
            end
            COMMIT: begin
                w_commit_now = 1'b1;
                w_state_nx   = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_datapath
        if (!rst_n) begin
            r_vblank_prv  <= 1'b0;
            r_pend        <= '0;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_first_vld   <= 1'b0;
            r_first_idx   <= '0;
            r_shadow      <= '0;
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_commit      <= 1'b0;
            r_timeout_err <= '0;
        end else begin
            r_vblank_prv <= vblank;
            r_commit     <= w_commit_now;

            if (w_snap) begin
                r_pend      <= req;
                r_first_vld <= 1'b0;
            end

            if (w_issue) begin
                r_grant <= w_pick_oh;
                r_gidx  <= w_pick_idx;
                r_cnt   <= '0;
                // Remember the frame's first owner to rotate fairness next frame.
                if (!r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_first_idx <= w_pick_idx;
                end
            end

            if (w_take) begin
                r_shadow[r_gidx].x <= cl_xpos[r_gidx];
                r_shadow[r_gidx].y <= cl_ypos[r_gidx];
                r_pend[r_gidx]     <= 1'b0;
                r_grant            <= '0;
            end

            if (w_tmo) begin
                r_timeout_err[r_gidx] <= 1'b1;
                r_pend[r_gidx]        <= 1'b0;
                r_grant               <= '0;
            end

            if (w_abort) begin
                r_pend  <= '0;
                r_grant <= '0;
            end

            if (w_cnt_inc) r_cnt <= r_cnt + c_cnt_w'(1);

            if (w_commit_now) begin
                for (int i = 0; i < N_CLIENTS; i++) begin
                    r_xpos[i] <= r_shadow[i].x;
                    r_ypos[i] <= r_shadow[i].y;
                end
                if (r_first_vld) begin
                    r_rr_ptr <= (r_first_idx == c_ptr_last) ? '0
                                                            : r_first_idx + c_ptr_w'(1);
                end
            end
        end
    end

    assign grant       = r_grant;
    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign commit      = r_commit;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rect_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rect_update_sched
// Description : Self-checking bench for rect_update_sched. Whole frames come
//               from a table of {req, silent clients, expected grant order,
//               expected sticky errors}; captured positions go through a
//               scoreboard queue that is drained at each commit. Abort,
//               stray-done and asynchronous reset are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_update_sched;

    localparam int N    = 4;
    localparam int SLOT = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vblank;
    logic [N-1:0]       req;
    logic [N-1:0]       done;
    logic [N-1:0][11:0] cl_xpos;
    logic [N-1:0][11:0] cl_ypos;
    logic [N-1:0]       grant;
    logic [N-1:0][11:0] xpos;
    logic [N-1:0][11:0] ypos;
    logic               commit;
    logic [N-1:0]       timeout_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] silent;
        int         n;
        int         seq [4];
        logic [3:0] tmo;
    } frame_t;

    typedef struct {
        int         idx;
        logic [11:0] x;
        logic [11:0] y;
    } upd_t;

    frame_t frames [5];
    upd_t   sb_q [$];
    int     exp_gq [$];

    logic [N-1:0][11:0] sh_x, sh_y, m_x, m_y;

    rect_update_sched #(
        .N_CLIENTS   (N),
        .SLOT_CYCLES (SLOT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblank      (vblank),
        .req         (req),
        .done        (done),
        .cl_xpos     (cl_xpos),
        .cl_ypos     (cl_ypos),
        .grant       (grant),
        .xpos        (xpos),
        .ypos        (ypos),
        .commit      (commit),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] px(input int f, input int i);
        if (f == 3 && i == 0) return 12'hFFF;
        return 12'(100 * (i + 1) + 8 * f);
    endfunction

    function automatic logic [11:0] py(input int f, input int i);
        return 12'(50 + 10 * i + f);
    endfunction

    task automatic idle_inputs();
        done    = '0;
        cl_xpos = {N{12'hABC}};
        cl_ypos = {N{12'h5A5}};
    endtask

    task automatic set_frame(input int k, input logic [3:0] rq, input logic [3:0] sil,
                             input int n, input int s0, input int s1, input int s2,
                             input int s3, input logic [3:0] tmo);
        frames[k].req    = rq;
        frames[k].silent = sil;
        frames[k].n      = n;
        frames[k].seq[0] = s0;
        frames[k].seq[1] = s1;
        frames[k].seq[2] = s2;
        frames[k].seq[3] = s3;
        frames[k].tmo    = tmo;
    endtask

    task automatic wait_grant(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 200) begin
            tick();
            n++;
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_commit(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (commit) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_commit_seen"}, 64'(seen), 64'd1);
    endtask

    // Sends a valid position from a granted client and records it.
    task automatic send_done(input int idx, input logic [11:0] x, input logic [11:0] y);
        upd_t u;
        cl_xpos[idx] = x;
        cl_ypos[idx] = y;
        done[idx]    = 1'b1;
        u.idx = idx;
        u.x   = x;
        u.y   = y;
        sb_q.push_back(u);
        tick();
        idle_inputs();
    endtask

    task automatic model_commit();
        upd_t u;
        while (sb_q.size() > 0) begin
            u = sb_q.pop_front();
            sh_x[u.idx] = u.x;
            sh_y[u.idx] = u.y;
        end
        m_x = sh_x;
        m_y = sh_y;
    endtask

    task automatic run_frame(input int k);
        int  lat;
        int  cnt;
        int  idx;
        bit  ok;
        string nm;
        exp_gq.delete();
        for (int i = 0; i < frames[k].n; i++) exp_gq.push_back(frames[k].seq[i]);
        req    = frames[k].req;
        vblank = 1'b1;
        for (int g = 0; g < frames[k].n; g++) begin
            nm = $sformatf("f%0d_g%0d", k, g);
            wait_grant(lat, ok);
            check({nm, "_grant_seen"}, 64'(ok), 64'd1);
            if (!ok) break;
            idx = exp_gq.pop_front();
            check({nm, "_grant"}, 64'(grant), 64'(4'(1) << idx));
            if (g == 0) check({nm, "_latency"}, 64'(lat), 64'd3);
            if (frames[k].silent[idx]) begin
                cnt = 0;
                while (grant != '0 && cnt < 200) begin
                    tick();
                    cnt++;
                end
                check({nm, "_timeout_hold"}, 64'(cnt), 64'(SLOT));
            end else begin
                repeat (5) tick();
                check({nm, "_grant_hold"}, 64'(grant), 64'(4'(1) << idx));
                send_done(idx, px(k, idx), py(k, idx));
                check({nm, "_grant_drop"}, 64'(grant), 64'd0);
            end
        end
        nm = $sformatf("f%0d", k);
        wait_commit(nm);
        model_commit();
        check({nm, "_xpos"}, 64'(xpos), 64'(m_x));
        check({nm, "_ypos"}, 64'(ypos), 64'(m_y));
        check({nm, "_timeout_err"}, 64'(timeout_err), 64'(frames[k].tmo));
        tick();
        check({nm, "_commit_pulse"}, 64'(commit), 64'd0);
        vblank = 1'b0;
        req    = '0;
        repeat (3) tick();
    endtask

    initial begin : main
        int lat;
        bit ok;
        rst_n  = 1'b0;
        vblank = 1'b0;
        req    = '0;
        idle_inputs();
        sh_x = '0; sh_y = '0; m_x = '0; m_y = '0;

        repeat (3) tick();
        check("rst_grant",   64'(grant),       64'd0);
        check("rst_xpos",    64'(xpos),        64'd0);
        check("rst_ypos",    64'(ypos),        64'd0);
        check("rst_commit",  64'(commit),      64'd0);
        check("rst_tmo",     64'(timeout_err), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        //         k  req      silent   n  order        tmo after frame
        set_frame(0, 4'b1011, 4'b0000, 3, 0, 1, 3, 0, 4'b0000);
        set_frame(1, 4'b1011, 4'b0000, 3, 1, 3, 0, 0, 4'b0000);
        set_frame(2, 4'b0111, 4'b0100, 3, 2, 0, 1, 0, 4'b0100);
        set_frame(3, 4'b1111, 4'b0000, 4, 3, 0, 1, 2, 4'b0100);
        set_frame(4, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0100);
        for (int k = 0; k < 5; k++) run_frame(k);

        // Stray done from client 2 while client 0 owns the slot, then vblank ends.
        req    = 4'b1111;
        vblank = 1'b1;
        wait_grant(lat, ok);
        check("s1_grant0", 64'(grant), 64'b0001);
        tick();
        cl_xpos[2] = 12'd777;
        cl_ypos[2] = 12'd777;
        done[2]    = 1'b1;
        tick();
        idle_inputs();
        check("s1_stray_ignored", 64'(grant), 64'b0001);
        tick();
        vblank = 1'b0;
        tick();
        check("s1_abort_drop", 64'(grant), 64'd0);
        wait_commit("s1");
        model_commit();
        check("s1_xpos_kept", 64'(xpos), 64'(m_x));
        check("s1_ypos_kept", 64'(ypos), 64'(m_y));
        check("s1_tmo_sticky", 64'(timeout_err), 64'b0100);
        req = '0;
        repeat (3) tick();

        // Abort after one client has finished: only that client changes.
        req    = 4'b1111;
        vblank = 1'b1;
        wait_grant(lat, ok);
        check("s2_grant1", 64'(grant), 64'b0010);
        repeat (2) tick();
        send_done(1, 12'd0, 12'hFFF);
        wait_grant(lat, ok);
        check("s2_grant2", 64'(grant), 64'b0100);
        vblank = 1'b0;
        tick();
        check("s2_abort_drop", 64'(grant), 64'd0);
        wait_commit("s2");
        model_commit();
        check("s2_xpos", 64'(xpos), 64'(m_x));
        check("s2_ypos", 64'(ypos), 64'(m_y));
        req = '0;
        repeat (3) tick();

        // Asynchronous reset while client 1 holds the slot.
        req    = 4'b0010;
        vblank = 1'b1;
        wait_grant(lat, ok);
        check("s3_grant1", 64'(grant), 64'b0010);
        #1 rst_n = 1'b0;
        #1;
        check("s3_rst_grant",  64'(grant),       64'd0);
        check("s3_rst_xpos",   64'(xpos),        64'd0);
        check("s3_rst_ypos",   64'(ypos),        64'd0);
        check("s3_rst_commit", 64'(commit),      64'd0);
        check("s3_rst_tmo",    64'(timeout_err), 64'd0);
        vblank = 1'b0;
        req    = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("s3_post_grant", 64'(grant), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
